// File: rtl/sig_add_arbiter.sv
// sig_add_arbiter: shares one significand add/abs unit among NUM_REQ requesters.
// Optional macro SIG_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module sig_add_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADD_LATENCY = 1,
  parameter int RSP_DEPTH   = 2,
  localparam int SW         = 42
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic [NUM_REQ-1:0]            REQ_LARGEST_SIGN,
  input  logic [NUM_REQ-1:0][1:0]       REQ_OP_SIGNS,
  input  logic [NUM_REQ-1:0][1:0][SW-1:0] REQ_SIGNIFICANDS,
  output logic                          ADD_DVI,
  output logic                          ADD_LARGEST_SIGN,
  output logic [1:0]                    ADD_OP_SIGNS,
  output logic [1:0][SW-1:0]            ADD_SIGNIFICANDS,
  input  logic                          ADD_SIGN,
  input  logic [SW-1:0]                 ADD_SUM,
  output logic [NUM_REQ-1:0]            RSP_VALID,
  input  logic [NUM_REQ-1:0]            RSP_READY,
  output logic                          RSP_SIGN,
  output logic [SW-1:0]                 RSP_SUM
);

  localparam int TW = $clog2(NUM_REQ);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;

  logic [TW-1:0] tag_mem_q [RSP_DEPTH];
  logic          sgn_mem_q [RSP_DEPTH];
  logic [SW-1:0] sum_mem_q [RSP_DEPTH];

  logic          ls_q;
  logic [1:0]    os_q;
  logic [1:0][SW-1:0] sig_q;

  logic          empty;
  logic          pop;
  logic          push;
  logic          credit_ok;
  logic          grant;
  logic          gnt_any;
  logic [TW-1:0] gnt_idx;
  logic [TW-1:0] base;
  logic [TW-1:0] head_tag;
  logic [TW-1:0] push_tag;
  logic [TW:0]   cand;

`ifdef SIG_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [TW-1:0] ptr_q, ptr_d;

  assign base = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (grant)
      ptr_d = (gnt_idx == TW'(NUM_REQ-1)) ? '0 : gnt_idx + TW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  // search upward from base with wrap; first valid requester wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, base} + (TW+1)'(i);
      if (cand >= (TW+1)'(NUM_REQ))
        cand = cand - (TW+1)'(NUM_REQ);
      if (!gnt_any && REQ_VALID[cand[TW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[TW-1:0];
      end
    end
  end

  assign empty     = (occ_q == '0);
  assign head_tag  = tag_mem_q[rd_q];
  assign pop       = !RST && !empty && RSP_READY[head_tag];
  assign credit_ok = (cnt_q < CW'(RSP_DEPTH)) || pop;
  assign grant     = !RST && gnt_any && credit_ok;

  always_comb begin
    REQ_READY = '0;
    if (grant) REQ_READY[gnt_idx] = 1'b1;
  end

  assign ADD_DVI = grant;

  always_comb begin
    ADD_LARGEST_SIGN = ls_q;
    ADD_OP_SIGNS     = os_q;
    ADD_SIGNIFICANDS = sig_q;
    if (grant) begin
      ADD_LARGEST_SIGN = REQ_LARGEST_SIGN[gnt_idx];
      ADD_OP_SIGNS     = REQ_OP_SIGNS[gnt_idx];
      ADD_SIGNIFICANDS = REQ_SIGNIFICANDS[gnt_idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ls_q  <= 1'b0;
      os_q  <= '0;
      sig_q <= '0;
    end else if (grant) begin
      ls_q  <= ADD_LARGEST_SIGN;
      os_q  <= ADD_OP_SIGNS;
      sig_q <= ADD_SIGNIFICANDS;
    end
  end

  generate
    if (ADD_LATENCY == 0) begin : g_lat0
      assign push     = grant;
      assign push_tag = gnt_idx;
    end else begin : g_lat1
      logic          tv_q;
      logic [TW-1:0] tt_q;
      always_ff @(posedge CLK) begin
        if (RST) begin
          tv_q <= 1'b0;
          tt_q <= '0;
        end else begin
          tv_q <= grant;
          tt_q <= gnt_idx;
        end
      end
      assign push     = tv_q;
      assign push_tag = tt_q;
    end
  endgenerate

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_d  = push ? inc(wr_q) : wr_q;
    rd_d  = pop  ? inc(rd_q) : rd_q;
    occ_d = occ_q + CW'(push) - CW'(pop);
    cnt_d = cnt_q + CW'(grant) - CW'(pop);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      occ_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      occ_q <= occ_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      tag_mem_q[wr_q] <= push_tag;
      sgn_mem_q[wr_q] <= ADD_SIGN;
      sum_mem_q[wr_q] <= ADD_SUM;
    end
  end

  always_comb begin
    RSP_VALID = '0;
    if (!RST && !empty) RSP_VALID[head_tag] = 1'b1;
  end

  assign RSP_SIGN = sgn_mem_q[rd_q];
  assign RSP_SUM  = sum_mem_q[rd_q];

endmodule

// File: tb/tb_sig_add_arbiter.sv
// tb_sig_add_arbiter: vector table, directed corner sequences and random
// traffic checked against a queue-based model of the shared adder arbiter.
module tb_sig_add_arbiter;

  localparam int N     = 4;
  localparam int LAT   = 1;
  localparam int DEPTH = 2;
  localparam int SW    = 42;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [N-1:0]           req_valid;
  logic [N-1:0]           req_ready;
  logic [N-1:0]           req_ls;
  logic [N-1:0][1:0]      req_os;
  logic [N-1:0][1:0][SW-1:0] req_sig;
  logic                   add_dvi;
  logic                   add_ls;
  logic [1:0]             add_os;
  logic [1:0][SW-1:0]     add_sig;
  logic                   add_sign;
  logic [SW-1:0]          add_sum;
  logic [N-1:0]           rsp_valid;
  logic [N-1:0]           rsp_ready;
  logic                   rsp_sign;
  logic [SW-1:0]          rsp_sum;

  sig_add_arbiter #(
    .NUM_REQ(N), .ADD_LATENCY(LAT), .RSP_DEPTH(DEPTH)
  ) dut (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_LARGEST_SIGN(req_ls), .REQ_OP_SIGNS(req_os),
    .REQ_SIGNIFICANDS(req_sig),
    .ADD_DVI(add_dvi), .ADD_LARGEST_SIGN(add_ls),
    .ADD_OP_SIGNS(add_os), .ADD_SIGNIFICANDS(add_sig),
    .ADD_SIGN(add_sign), .ADD_SUM(add_sum),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
    .RSP_SIGN(rsp_sign), .RSP_SUM(rsp_sum)
  );

  // signed add then absolute value: {sign, magnitude}
  function automatic logic [SW:0] f_add(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [SW-1:0] s;
    s = a + b;
    return s[SW-1] ? {1'b1, -s} : {1'b0, s};
  endfunction

  logic          add_sign_r;
  logic [SW-1:0] add_sum_r;
  always @(posedge clk)
    if (add_dvi) {add_sign_r, add_sum_r} <= f_add(add_sig[0], add_sig[1]);
  assign {add_sign, add_sum} = (LAT == 0) ? f_add(add_sig[0], add_sig[1])
                                          : {add_sign_r, add_sum_r};

  typedef struct {
    int            tag;
    logic          sign;
    logic [SW-1:0] mag;
    int            vis;
  } op_t;

  op_t mq[$];
  int  cyc = 0;
  int  ptr = 0;
  int  errors = 0;
  int  checks = 0;
  logic have_last = 1'b0;
  logic last_ls;
  logic [1:0] last_os;
  logic [1:0][SW-1:0] last_sig;
  logic e_grant = 1'b0;
  logic e_pop = 1'b0;
  int   e_g = 0;
  logic [N-1:0]  s_ready, s_rv;
  logic [SW-1:0] s_sum;
  logic          s_sign;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_cycle();
    logic head_vis;
    int g;
    logic [N-1:0] exp_ready, exp_rv;
    head_vis = !rst && mq.size() > 0 && mq[0].vis <= cyc;
    e_pop = head_vis && rsp_ready[mq[0].tag];
    e_grant = 1'b0;
    e_g = 0;
    if (!rst && (mq.size() < DEPTH || e_pop)) begin
      for (int k = 0; k < N; k++) begin
`ifdef SIG_ARB_FIXED_PRIO_EN
        g = k;
`else
        g = (ptr + k) % N;
`endif
        if (!e_grant && req_valid[g]) begin
          e_grant = 1'b1;
          e_g = g;
        end
      end
    end
    exp_ready = e_grant ? (N'(1) << e_g) : '0;
    exp_rv = head_vis ? (N'(1) << mq[0].tag) : '0;
    chk("req_ready", req_ready, exp_ready);
    chk("add_dvi", add_dvi, e_grant);
    chk("rsp_valid", rsp_valid, exp_rv);
    if (head_vis) begin
      chk("rsp_sum", rsp_sum, mq[0].mag);
      chk("rsp_sign", rsp_sign, mq[0].sign);
    end
    if (e_grant) begin
      chk("add_ls", add_ls, req_ls[e_g]);
      chk("add_os", add_os, req_os[e_g]);
      chk("add_sig", add_sig, req_sig[e_g]);
    end else if (have_last && !rst) begin
      chk("add_hold_ls", add_ls, last_ls);
      chk("add_hold_os", add_os, last_os);
      chk("add_hold_sig", add_sig, last_sig);
    end
    s_ready = req_ready;
    s_rv    = rsp_valid;
    s_sum   = rsp_sum;
    s_sign  = rsp_sign;
  endtask

  task automatic update_model();
    op_t o;
    logic [SW:0] r;
    if (rst) begin
      mq.delete();
      ptr = 0;
      have_last = 1'b0;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (e_grant) begin
        r = f_add(req_sig[e_g][0], req_sig[e_g][1]);
        o.tag = e_g;
        o.sign = r[SW];
        o.mag = r[SW-1:0];
        o.vis = cyc + LAT + 1;
        mq.push_back(o);
        ptr = (e_g + 1) % N;
        have_last = 1'b1;
        last_ls = req_ls[e_g];
        last_os = req_os[e_g];
        last_sig = req_sig[e_g];
      end
    end
    cyc++;
  endtask

  // entered and left at posedge+1
  task automatic cycle();
    #4;
    check_cycle();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic rand_reqs();
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] || (e_grant && e_g == i)) begin
        req_valid[i] = ($urandom_range(0, 9) < 6);
        req_ls[i] = 1'($urandom);
        req_os[i] = 2'($urandom);
        req_sig[i][0] = SW'({$urandom, $urandom});
        req_sig[i][1] = SW'({$urandom, $urandom});
      end
    end
  endtask

  typedef struct {
    int            r;
    logic [SW-1:0] a;
    logic [SW-1:0] b;
    logic          sign;
    logic [SW-1:0] mag;
  } vec_t;

  vec_t vt[6];
  int   grants;

  initial begin
    vt[0] = '{2, 42'd100, -42'd30, 1'b0, 42'd70};
    vt[1] = '{0, -42'd5, 42'd3, 1'b1, 42'd2};
    vt[2] = '{3, -42'd100, -42'd200, 1'b1, 42'd300};
    vt[3] = '{1, 42'd1000, -42'd1000, 1'b0, 42'd0};
    vt[4] = '{1, 42'd12345, 42'd1, 1'b0, 42'd12346};
    vt[5] = '{0, 42'h0FF_FFFF_FFFF, 42'h0FF_FFFF_FFFF, 1'b0, 42'h1FF_FFFF_FFFE};

    rst = 1'b1;
    req_valid = '1;
    rsp_ready = '1;
    for (int i = 0; i < N; i++) begin
      req_ls[i] = i[0];
      req_os[i] = 2'(i);
      req_sig[i][0] = SW'(10 * (i + 1));
      req_sig[i][1] = SW'(i + 1);
    end
    @(posedge clk);
    #1;

    // reset held with all requesters valid
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("rst_ready", s_ready, '0);
      chk("rst_rsp_valid", s_rv, '0);
    end
    rst = 1'b0;

`ifndef SIG_ARB_FIXED_PRIO_EN
    begin
      int rr_exp[5] = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 7; k++) begin
        cycle();
        if (k < 5) chk("rr_grant", s_ready, N'(1) << rr_exp[k]);
        if (k >= LAT + 1) chk("rr_rsp", s_rv, N'(1) << rr_exp[k-LAT-1]);
      end
    end
`else
    cycle();
    chk("first_grant", s_ready, N'(1));
`endif

    req_valid = '0;
    for (int k = 0; k < 4; k++) cycle();

    // single-operation vectors through the tag pipe
    foreach (vt[v]) begin
      req_valid = N'(1) << vt[v].r;
      req_sig[vt[v].r][0] = vt[v].a;
      req_sig[vt[v].r][1] = vt[v].b;
      req_ls[vt[v].r] = 1'($urandom);
      req_os[vt[v].r] = 2'($urandom);
      cycle();
      chk("vec_grant", s_ready, N'(1) << vt[v].r);
      req_valid = '0;
      for (int d = 1; d <= LAT + 1; d++) begin
        cycle();
        if (d <= LAT) chk("vec_early", s_rv, '0);
      end
      chk("vec_rsp_valid", s_rv, N'(1) << vt[v].r);
      chk("vec_rsp_sum", s_sum, vt[v].mag);
      chk("vec_rsp_sign", s_sign, vt[v].sign);
      cycle();
    end

    // credits and head-of-line blocking
    rst = 1'b1;
    req_valid = '0;
    cycle();
    rst = 1'b0;
    rsp_ready = '0;
    req_valid = '1;
    grants = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (s_ready != '0) grants++;
    end
    chk("credit_grants", grants, DEPTH);
    chk("credit_stall", s_ready, '0);
    rsp_ready = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("hol_rsp_valid", s_rv, 4'b0001);
      chk("hol_ready", s_ready, '0);
    end
    rsp_ready = 4'b0001;
    cycle();
    chk("resume_rsp_valid", s_rv, 4'b0001);
`ifndef SIG_ARB_FIXED_PRIO_EN
    chk("resume_grant", s_ready, 4'b0100);
`else
    chk("resume_grant", s_ready, 4'b0001);
`endif
    cycle();
    chk("order_rsp_valid", s_rv, 4'b0010);
    chk("order_stall", s_ready, '0);
    rsp_ready = '1;
    req_valid = '0;
    for (int k = 0; k < 4; k++) cycle();

`ifdef SIG_ARB_FIXED_PRIO_EN
    req_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("fp_grant1", s_ready, 4'b0010);
    end
    req_valid = 4'b1000;
    cycle();
    chk("fp_grant3", s_ready, 4'b1000);
    req_valid = '0;
    for (int k = 0; k < 4; k++) cycle();
`endif

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
      rand_reqs();
      cycle();
    end

    rst = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    for (int k = 0; k < 6; k++) cycle();
    chk("drained", mq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
